// File: rtl/demux_fifo_pkg.sv
// Shared constants for the 1-to-2 demux FIFO router.
// Channel indices and default FIFO geometry.
package demux_fifo_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 4;
   localparam int DEF_CNT_W  = 16;

   localparam int PTR_W = $clog2(DEF_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   localparam logic CH1 = 1'b0;
   localparam logic CH2 = 1'b1;

   // Occupancy width for an arbitrary power-of-2 depth
   function automatic int occ_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word.
// Head reads 0 whenever the FIFO is empty.
module sync_fifo
   import demux_fifo_pkg::*;
#(
   parameter int DW    = DEF_DATA_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic          full,
   output logic          empty,
   output logic [DW-1:0] head
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = occ_w(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [OW-1:0] occ;
   logic [DW-1:0] head_q;

   logic          do_push;
   logic          do_pop;
   logic [PW-1:0] rptr_n;
   logic [OW-1:0] occ_n;
   logic [DW-1:0] head_n;

   assign full    = (occ == OW'(DEPTH));
   assign empty   = (occ == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = head_q;

   // Next read pointer, occupancy and head word
   always_comb begin
      rptr_n = rptr + PW'(do_pop);
      occ_n  = occ + OW'(do_push) - OW'(do_pop);
      head_n = '0;
      if (occ_n != '0) begin
         if (do_push && (rptr_n == wptr))
            head_n = din;
         else
            head_n = mem[rptr_n];
      end
   end

   // Storage array; contents are never exposed while empty
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wptr] <= din;
   end

   // Pointers, occupancy and registered head
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr   <= '0;
         rptr   <= '0;
         occ    <= '0;
         head_q <= '0;
      end else begin
         wptr   <= wptr + PW'(do_push);
         rptr   <= rptr_n;
         occ    <= occ_n;
         head_q <= head_n;
      end
   end

endmodule

// File: rtl/demux_fifo_router.sv
// 1-to-2 stream distributor: Sel steers words into two FIFOs.
// Each channel drains on its own valid/ready port.
module demux_fifo_router
   import demux_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_W,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int CNT_WIDTH  = DEF_CNT_W
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] IN_DATA,
   input  logic                  IN_VALID,
   input  logic                  Sel,
   output logic                  IN_READY,
   output logic [DATA_WIDTH-1:0] OUT1_DATA,
   output logic                  OUT1_VALID,
   input  logic                  OUT1_READY,
   output logic [DATA_WIDTH-1:0] OUT2_DATA,
   output logic                  OUT2_VALID,
   input  logic                  OUT2_READY,
   output logic [CNT_WIDTH-1:0]  CNT1,
   output logic [CNT_WIDTH-1:0]  CNT2
);

   logic full1;
   logic full2;
   logic empty1;
   logic empty2;
   logic push1;
   logic push2;
   logic pop1;
   logic pop2;

   logic [CNT_WIDTH-1:0] cnt1_q;
   logic [CNT_WIDTH-1:0] cnt2_q;

   assign IN_READY = (Sel == CH2) ? ~full2 : ~full1;

   assign push1 = IN_VALID & IN_READY & (Sel == CH1);
   assign push2 = IN_VALID & IN_READY & (Sel == CH2);

   assign pop1 = OUT1_READY & ~empty1;
   assign pop2 = OUT2_READY & ~empty2;

   assign OUT1_VALID = ~empty1;
   assign OUT2_VALID = ~empty2;

   assign CNT1 = cnt1_q;
   assign CNT2 = cnt2_q;

   sync_fifo #(
      .DW    (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo1 (
      .clk   (CLK),
      .rst   (RST),
      .push  (push1),
      .pop   (pop1),
      .din   (IN_DATA),
      .full  (full1),
      .empty (empty1),
      .head  (OUT1_DATA)
   );

   sync_fifo #(
      .DW    (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo2 (
      .clk   (CLK),
      .rst   (RST),
      .push  (push2),
      .pop   (pop2),
      .din   (IN_DATA),
      .full  (full2),
      .empty (empty2),
      .head  (OUT2_DATA)
   );

   // Accepted-word counters, wrapping at 2^CNT_WIDTH
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else begin
         if (push1)
            cnt1_q <= cnt1_q + 1'b1;
         if (push2)
            cnt2_q <= cnt2_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_demux_fifo_router.sv
// Bench for demux_fifo_router: table vectors, directed corners,
// and random traffic against a queue-based reference model.
module tb_demux_fifo_router;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        iv;
   logic        sel;
   logic        r1;
   logic        r2;
   logic [31:0] din;

   logic        ir;
   logic        v1;
   logic        v2;
   logic [31:0] d1;
   logic [31:0] d2;
   logic [15:0] c1;
   logic [15:0] c2;

   logic        ir_b;
   logic        v1_b;
   logic        v2_b;
   logic [31:0] d1_b;
   logic [31:0] d2_b;
   logic [3:0]  c1_b;
   logic [3:0]  c2_b;

   int checks = 0;
   int errors = 0;

   logic [31:0] q1[$];
   logic [31:0] q2[$];
   int m1 = 0;
   int m2 = 0;

   demux_fifo_router dut (
      .CLK        (clk),
      .RST        (rst),
      .IN_DATA    (din),
      .IN_VALID   (iv),
      .Sel        (sel),
      .IN_READY   (ir),
      .OUT1_DATA  (d1),
      .OUT1_VALID (v1),
      .OUT1_READY (r1),
      .OUT2_DATA  (d2),
      .OUT2_VALID (v2),
      .OUT2_READY (r2),
      .CNT1       (c1),
      .CNT2       (c2)
   );

   demux_fifo_router #(.CNT_WIDTH(4)) dut4 (
      .CLK        (clk),
      .RST        (rst),
      .IN_DATA    (din),
      .IN_VALID   (iv),
      .Sel        (sel),
      .IN_READY   (ir_b),
      .OUT1_DATA  (d1_b),
      .OUT1_VALID (v1_b),
      .OUT1_READY (r1),
      .OUT2_DATA  (d2_b),
      .OUT2_VALID (v2_b),
      .OUT2_READY (r2),
      .CNT1       (c1_b),
      .CNT2       (c2_b)
   );

   typedef struct {
      logic        v;
      logic        s;
      logic        a;
      logic        b;
      logic [31:0] d;
      logic        eir;
      logic        ev1;
      logic [31:0] ed1;
      logic        ev2;
      logic [31:0] ed2;
      logic [15:0] ec1;
      logic [15:0] ec2;
   } vec_t;

   vec_t tbl[4];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic mready();
      if (sel)
         return q2.size() < DEPTH;
      return q1.size() < DEPTH;
   endfunction

   task automatic drive(input logic v, input logic s, input logic a,
                        input logic b, input logic [31:0] d);
      @(negedge clk);
      rst = 1'b0;
      iv  = v;
      sel = s;
      r1  = a;
      r2  = b;
      din = d;
      #1;
   endtask

   task automatic model_check();
      logic [31:0] h1;
      logic [31:0] h2;
      h1 = (q1.size() != 0) ? q1[0] : 32'h0;
      h2 = (q2.size() != 0) ? q2[0] : 32'h0;
      chk("in_ready", 32'(ir), 32'(mready()));
      chk("in_ready_w4", 32'(ir_b), 32'(mready()));
      chk("out1_valid", 32'(v1), 32'(q1.size() != 0));
      chk("out1_data", d1, h1);
      chk("out2_valid", 32'(v2), 32'(q2.size() != 0));
      chk("out2_data", d2, h2);
      chk("cnt1", 32'(c1), 32'(m1 % 65536));
      chk("cnt2", 32'(c2), 32'(m2 % 65536));
      chk("cnt1_w4", 32'(c1_b), 32'(m1 % 16));
      chk("cnt2_w4", 32'(c2_b), 32'(m2 % 16));
   endtask

   task automatic advance();
      logic p;
      p = iv && mready();
      if (r1 && q1.size() > 0)
         void'(q1.pop_front());
      if (r2 && q2.size() > 0)
         void'(q2.pop_front());
      if (p) begin
         if (!sel) begin
            q1.push_back(din);
            m1++;
         end else begin
            q2.push_back(din);
            m2++;
         end
      end
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      iv  = 1'b1;
      sel = 1'($urandom);
      r1  = 1'($urandom);
      r2  = 1'($urandom);
      din = $urandom;
      @(posedge clk);
      q1.delete();
      q2.delete();
      m1 = 0;
      m2 = 0;
   endtask

   initial begin
      logic [31:0] sw[12];
      int k;
      int e;

      rst = 1'b1;
      iv  = 1'b0;
      sel = 1'b0;
      r1  = 1'b0;
      r2  = 1'b0;
      din = '0;
      repeat (2) @(posedge clk);

      // Steering table: inputs and the outputs seen before that edge
      tbl[0] = '{1, 0, 1, 1, 32'hA0000001,
                 1, 0, 32'h0, 0, 32'h0, 16'd0, 16'd0};
      tbl[1] = '{1, 1, 1, 1, 32'hB0000002,
                 1, 1, 32'hA0000001, 0, 32'h0, 16'd1, 16'd0};
      tbl[2] = '{0, 0, 1, 1, 32'h0,
                 1, 0, 32'h0, 1, 32'hB0000002, 16'd1, 16'd1};
      tbl[3] = '{0, 1, 1, 1, 32'h0,
                 1, 0, 32'h0, 0, 32'h0, 16'd1, 16'd1};

      for (int i = 0; i < 4; i++) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].d);
         chk("tbl_ir", 32'(ir), 32'(tbl[i].eir));
         chk("tbl_v1", 32'(v1), 32'(tbl[i].ev1));
         chk("tbl_d1", d1, tbl[i].ed1);
         chk("tbl_v2", 32'(v2), 32'(tbl[i].ev2));
         chk("tbl_d2", d2, tbl[i].ed2);
         chk("tbl_c1", 32'(c1), 32'(tbl[i].ec1));
         chk("tbl_c2", 32'(c2), 32'(tbl[i].ec2));
         advance();
      end

      // Full / backpressure / independence
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         drive(1, 0, 0, 1, 32'hC0000000 + 32'(i));
         model_check();
         advance();
      end
      drive(1, 0, 0, 1, 32'hC0000005);
      chk("full_ir", 32'(ir), 32'h0);
      model_check();
      advance();
      drive(1, 1, 0, 1, 32'hD0000001);
      chk("indep_ir", 32'(ir), 32'h1);
      model_check();
      advance();
      drive(1, 1, 0, 1, 32'hD0000002);
      chk("indep_v2", 32'(v2), 32'h1);
      chk("indep_d2", d2, 32'hD0000001);
      model_check();
      advance();
      k = 5;
      e = 1;
      for (int i = 0; i < 8; i++) begin
         drive(k <= 5, 0, 1, 1, 32'hC0000000 + 32'(k));
         model_check();
         if (v1) begin
            chk("drain_order", d1, 32'hC0000000 + 32'(e));
            e++;
         end
         if (iv && ir)
            k++;
         advance();
      end
      drive(0, 0, 1, 1, 32'h0);
      chk("cnt1_five", 32'(c1), 32'd5);
      chk("drain_v1", 32'(v1), 32'h0);
      advance();

      // Streaming push+pop with two entries resident
      do_reset();
      for (int i = 0; i < 12; i++)
         sw[i] = $urandom;
      drive(1, 0, 0, 0, sw[0]);
      advance();
      drive(1, 0, 0, 0, sw[1]);
      advance();
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 1, 0, sw[i+2]);
         chk("stream_v1", 32'(v1), 32'h1);
         chk("stream_d1", d1, sw[i]);
         chk("stream_ir", 32'(ir), 32'h1);
         advance();
      end
      drive(0, 0, 1, 0, 32'h0);
      chk("tail_d1a", d1, sw[10]);
      advance();
      drive(0, 0, 1, 0, 32'h0);
      chk("tail_d1b", d1, sw[11]);
      advance();
      drive(0, 0, 1, 0, 32'h0);
      chk("tail_empty", 32'(v1), 32'h0);
      chk("tail_d1z", d1, 32'h0);
      advance();

      // Counter wrap on the 4-bit instance
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(1, 1, 1, 1, $urandom);
         model_check();
         advance();
      end
      drive(0, 1, 1, 1, 32'h0);
      chk("wrap_cnt2_w4", 32'(c2_b), 32'd1);
      chk("cnt2_17", 32'(c2), 32'd17);
      advance();

      // Reset mid-traffic
      for (int i = 0; i < 20; i++) begin
         drive(1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
         advance();
      end
      do_reset();
      drive(0, 0, 0, 0, 32'h0);
      chk("rst_ir", 32'(ir), 32'h1);
      chk("rst_v1", 32'(v1), 32'h0);
      chk("rst_v2", 32'(v2), 32'h0);
      chk("rst_d1", d1, 32'h0);
      chk("rst_d2", d2, 32'h0);
      chk("rst_c1", 32'(c1), 32'h0);
      chk("rst_c2", 32'(c2), 32'h0);
      advance();

      // Random traffic against the queue model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 2) != 0), $urandom);
            model_check();
            advance();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
